// File: rtl/fault_cmd_sequencer_if.sv
// Host descriptor channel for fault_cmd_sequencer.
//   valid/ready : descriptor handshake (transfer when both high)
//   cmd         : debug command code
//   data0       : word-select value
//   data1       : bit-select value
//   delay       : idle cycles before each issue
//   rpt         : extra issues after the first
interface fault_cmd_sequencer_if #(
  parameter int unsigned COMMAND_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned DELAY_W       = 16
);
  logic                     valid;
  logic                     ready;
  logic [COMMAND_WIDTH-1:0] cmd;
  logic [WORD_W-1:0]        data0;
  logic [DATA_WIDTH-1:0]    data1;
  logic [DELAY_W-1:0]       delay;
  logic [7:0]               rpt;

  modport master (output valid, cmd, data0, data1, delay, rpt, input ready);
  modport slave  (input  valid, cmd, data0, data1, delay, rpt, output ready);
endinterface

// File: rtl/fault_cmd_sequencer.sv
// Fault command sequencer: queues host descriptors and replays each one as
// debug-port command strobes with a programmable pre-issue delay, a fixed
// two-cycle gap after every strobe, and a repeat count.
//   clk_i, rst_ni     : clock, async active-low reset
//   host              : descriptor channel (slave side)
//   abort_i           : flush queue and return to IDLE
//   clear_status_i    : clear check_seen_o and issue_count_o
//   cmd_*_o           : debug-port command strobe and payload (zero when idle)
//   state0_i          : debug-port status bit 0
//   busy_o            : FSM active or queue non-empty
//   done_o            : one-cycle pulse at descriptor completion
//   issue_count_o     : saturating count of strobes issued
//   check_seen_o      : sticky capture of state0_i
module fault_cmd_sequencer #(
  parameter int unsigned COMMAND_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned DELAY_W       = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  fault_cmd_sequencer_if.slave     host,
  input  logic                     abort_i,
  input  logic                     clear_status_i,
  output logic                     cmd_valid_o,
  output logic [COMMAND_WIDTH-1:0] cmd_command_o,
  output logic [WORD_W-1:0]        cmd_data0_o,
  output logic [DATA_WIDTH-1:0]    cmd_data1_o,
  input  logic                     state0_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [15:0]              issue_count_o,
  output logic                     check_seen_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [COMMAND_WIDTH-1:0] cmd;
    logic [WORD_W-1:0]        data0;
    logic [DATA_WIDTH-1:0]    data1;
    logic [DELAY_W-1:0]       delay;
    logic [7:0]               rpt;
  } desc_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE, ST_GAP} state_e;

  state_e             state_q;
  desc_t              mem_q [FIFO_DEPTH];
  desc_t              desc_in, head;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               full, empty, push, pop;

  logic [COMMAND_WIDTH-1:0] cur_cmd_q;
  logic [WORD_W-1:0]        cur_d0_q;
  logic [DATA_WIDTH-1:0]    cur_d1_q;
  logic [DELAY_W-1:0]       cur_delay_q;
  logic [DELAY_W-1:0]       wait_q;
  logic [7:0]               rpt_q;
  logic                     gap_q;

  assign desc_in = '{cmd: host.cmd, data0: host.data0, data1: host.data1,
                     delay: host.delay, rpt: host.rpt};
  assign head    = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign host.ready = !full && !abort_i;
  assign push    = host.valid && host.ready;
  // Pop is only taken from registered occupancy, so a same-cycle push never bypasses.
  assign pop     = (state_q == ST_IDLE) && !empty && !abort_i;
  assign busy_o  = (state_q != ST_IDLE) || !empty;

  // Descriptor storage (pointer-indexed, no reset needed)
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= desc_in;
  end

  // Queue pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Sequencer FSM; strobe and done are registered on the edge entering ISSUE / leaving GAP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cur_cmd_q     <= '0;
      cur_d0_q      <= '0;
      cur_d1_q      <= '0;
      cur_delay_q   <= '0;
      wait_q        <= '0;
      rpt_q         <= '0;
      gap_q         <= 1'b0;
      cmd_valid_o   <= 1'b0;
      cmd_command_o <= '0;
      cmd_data0_o   <= '0;
      cmd_data1_o   <= '0;
      done_o        <= 1'b0;
    end else begin
      cmd_valid_o   <= 1'b0;
      cmd_command_o <= '0;
      cmd_data0_o   <= '0;
      cmd_data1_o   <= '0;
      done_o        <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pop) begin
              cur_cmd_q   <= head.cmd;
              cur_d0_q    <= head.data0;
              cur_d1_q    <= head.data1;
              cur_delay_q <= head.delay;
              rpt_q       <= head.rpt;
              if (head.cmd == '0) begin
                // Null command: consumed silently
                done_o <= 1'b1;
              end else if (head.delay == '0) begin
                state_q       <= ST_ISSUE;
                cmd_valid_o   <= 1'b1;
                cmd_command_o <= head.cmd;
                cmd_data0_o   <= head.data0;
                cmd_data1_o   <= head.data1;
              end else begin
                state_q <= ST_WAIT;
                wait_q  <= head.delay;
              end
            end
          end
          ST_WAIT: begin
            if (wait_q == DELAY_W'(1)) begin
              state_q       <= ST_ISSUE;
              cmd_valid_o   <= 1'b1;
              cmd_command_o <= cur_cmd_q;
              cmd_data0_o   <= cur_d0_q;
              cmd_data1_o   <= cur_d1_q;
            end else begin
              wait_q <= wait_q - DELAY_W'(1);
            end
          end
          ST_ISSUE: begin
            state_q <= ST_GAP;
            gap_q   <= 1'b0;
          end
          ST_GAP: begin
            if (!gap_q) begin
              gap_q <= 1'b1;
            end else if (rpt_q != 8'd0) begin
              rpt_q <= rpt_q - 8'd1;
              if (cur_delay_q == '0) begin
                state_q       <= ST_ISSUE;
                cmd_valid_o   <= 1'b1;
                cmd_command_o <= cur_cmd_q;
                cmd_data0_o   <= cur_d0_q;
                cmd_data1_o   <= cur_d1_q;
              end else begin
                state_q <= ST_WAIT;
                wait_q  <= cur_delay_q;
              end
            end else begin
              done_o  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Saturating issue counter; clear wins over a same-cycle increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_count_o <= '0;
    end else if (clear_status_i) begin
      issue_count_o <= '0;
    end else if (cmd_valid_o && (issue_count_o != 16'hFFFF)) begin
      issue_count_o <= issue_count_o + 16'd1;
    end
  end

  // Sticky status capture; a new set wins over clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      check_seen_o <= 1'b0;
    end else if (state0_i) begin
      check_seen_o <= 1'b1;
    end else if (clear_status_i) begin
      check_seen_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fault_cmd_sequencer.sv
// Scoreboard bench for fault_cmd_sequencer: directed descriptors with
// hand-computed strobe/done cycles queued as expectations; a monitor process
// compares every strobe and done pulse against the queue head.
module tb_fault_cmd_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        abort_i = 1'b0;
  logic        clear_status_i = 1'b0;
  logic        state0_i = 1'b0;
  logic        cmd_valid_o;
  logic [7:0]  cmd_command_o;
  logic [31:0] cmd_data0_o;
  logic [63:0] cmd_data1_o;
  logic        busy_o, done_o, check_seen_o;
  logic [15:0] issue_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] d0;
    logic [63:0] d1;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  fault_cmd_sequencer_if #(.COMMAND_WIDTH(8), .DATA_WIDTH(64), .WORD_W(32), .DELAY_W(16)) host_if ();

  fault_cmd_sequencer #(
    .COMMAND_WIDTH(8), .DATA_WIDTH(64), .WORD_W(32), .DELAY_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .host(host_if),
    .abort_i(abort_i), .clear_status_i(clear_status_i),
    .cmd_valid_o(cmd_valid_o), .cmd_command_o(cmd_command_o),
    .cmd_data0_o(cmd_data0_o), .cmd_data1_o(cmd_data1_o),
    .state0_i(state0_i), .busy_o(busy_o), .done_o(done_o),
    .issue_count_o(issue_count_o), .check_seen_o(check_seen_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic exp_strobe(input logic [7:0] c, input logic [31:0] d0, input logic [63:0] d1, input int at);
    exp_t e;
    e.cmd = c; e.d0 = d0; e.d1 = d1; e.at = at;
    exp_q.push_back(e);
  endtask

  // Offer a descriptor from posedge+1; returns the cycle in which it was accepted
  task automatic push(input logic [7:0] c, input logic [31:0] d0, input logic [63:0] d1,
                      input logic [15:0] dl, input logic [7:0] rp, output int t);
    bit got = 0;
    host_if.valid = 1'b1; host_if.cmd = c; host_if.data0 = d0; host_if.data1 = d1;
    host_if.delay = dl;   host_if.rpt = rp;
    t = -1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk_i);
      if (host_if.ready) begin
        t = cyc;
        got = 1;
      end
      @(posedge clk_i);
      #1;
    end
    host_if.valid = 1'b0;
    if (!got) chk("push_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    tick(1);
    @(negedge clk_i);
    while (busy_o && k < max) begin
      @(negedge clk_i);
      k++;
    end
    chk("wait_idle_busy", 64'(busy_o), 64'd0);
    tick(1);
  endtask

  // Monitor: every strobe/done must match the expectation queue head
  initial begin : monitor
    exp_t e;
    int   d;
    forever begin
      @(negedge clk_i);
      if (cmd_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 64'(cmd_command_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cmd",   64'(cmd_command_o), 64'(e.cmd));
          chk("strobe_data0", 64'(cmd_data0_o),   64'(e.d0));
          chk("strobe_data1", cmd_data1_o,        e.d1);
          chk("strobe_cycle", 64'(cyc),           64'(e.at));
        end
      end else if ((cmd_command_o != 8'd0) || (cmd_data0_o != 32'd0) || (cmd_data1_o != 64'd0)) begin
        chk("idle_fields_zero", 64'd1, 64'd0);
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, t0;
    host_if.valid = 1'b0; host_if.cmd = '0; host_if.data0 = '0;
    host_if.data1 = '0;   host_if.delay = '0; host_if.rpt = '0;
    #1;
    chk("rst_cmd_valid",   64'(cmd_valid_o),   64'd0);
    chk("rst_cmd_fields",  64'(cmd_command_o | 8'(cmd_data0_o != 0) | 8'(cmd_data1_o != 0)), 64'd0);
    chk("rst_done",        64'(done_o),        64'd0);
    chk("rst_issue_count", 64'(issue_count_o), 64'd0);
    chk("rst_check_seen",  64'(check_seen_o),  64'd0);
    chk("rst_busy",        64'(busy_o),        64'd0);
    chk("rst_ready",       64'(host_if.ready), 64'd1);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    tick(2);

    // Single issue, no delay
    push(8'd1, 32'd5, 64'd17, 16'd0, 8'd0, t);
    exp_strobe(8'd1, 32'd5, 64'd17, t + 2);
    done_q.push_back(t + 5);
    wait_idle(50);
    chk("count_after_single", 64'(issue_count_o), 64'd1);

    clear_status_i = 1'b1; tick(1); clear_status_i = 1'b0;
    chk("count_cleared", 64'(issue_count_o), 64'd0);

    // Delay 3, two repeats
    push(8'd1, 32'hA, 64'hB, 16'd3, 8'd2, t);
    exp_strobe(8'd1, 32'hA, 64'hB, t + 5);
    exp_strobe(8'd1, 32'hA, 64'hB, t + 11);
    exp_strobe(8'd1, 32'hA, 64'hB, t + 17);
    done_q.push_back(t + 20);
    wait_idle(80);
    chk("count_after_repeat", 64'(issue_count_o), 64'd3);

    // Null command: consumed, done the cycle after pop, no strobe
    push(8'd0, 32'h1, 64'h2, 16'd5, 8'd3, t);
    done_q.push_back(t + 2);
    wait_idle(30);
    chk("count_after_null", 64'(issue_count_o), 64'd3);

    // Delay 1, one repeat, wide payload
    push(8'h5A, 32'hDEADBEEF, 64'h0123456789ABCDEF, 16'd1, 8'd1, t);
    exp_strobe(8'h5A, 32'hDEADBEEF, 64'h0123456789ABCDEF, t + 3);
    exp_strobe(8'h5A, 32'hDEADBEEF, 64'h0123456789ABCDEF, t + 7);
    done_q.push_back(t + 10);
    wait_idle(50);

    // Delay 0, two repeats
    push(8'hC3, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 8'd2, t);
    exp_strobe(8'hC3, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, t + 2);
    exp_strobe(8'hC3, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, t + 5);
    exp_strobe(8'hC3, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, t + 8);
    done_q.push_back(t + 11);
    wait_idle(50);

    // Queue fills while the FSM sits in a long delay
    push(8'd2, 32'd2, 64'd2, 16'd40, 8'd0, t0);
    exp_strobe(8'd2, 32'd2, 64'd2, t0 + 42);
    done_q.push_back(t0 + 45);
    for (int k = 3; k <= 7; k++) begin
      exp_strobe(8'(k), 32'(k), 64'(k), t0 + 46 + 4 * (k - 3));
      done_q.push_back(t0 + 49 + 4 * (k - 3));
    end
    tick(3);
    for (int k = 3; k <= 6; k++) push(8'(k), 32'(k), 64'(k), 16'd0, 8'd0, t);
    @(negedge clk_i);
    chk("ready_low_when_full", 64'(host_if.ready), 64'd0);
    tick(1);
    push(8'd7, 32'd7, 64'd7, 16'd0, 8'd0, t);
    chk("fifth_accept_cycle", 64'(t), 64'(t0 + 46));
    wait_idle(150);

    // Abort while waiting with two queued behind
    push(8'd8, 32'd8, 64'd8, 16'd30, 8'd0, t);
    tick(2);
    push(8'd9, 32'd9, 64'd9, 16'd0, 8'd0, t);
    push(8'd10, 32'd10, 64'd10, 16'd0, 8'd0, t);
    tick(4);
    abort_i = 1'b1;
    @(negedge clk_i);
    chk("ready_low_in_abort", 64'(host_if.ready), 64'd0);
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("busy_after_abort", 64'(busy_o), 64'd0);
    tick(45);
    chk("busy_long_after_abort", 64'(busy_o), 64'd0);

    // Sticky status and saturation
    state0_i = 1'b1; tick(1); state0_i = 1'b0;
    chk("check_seen_set", 64'(check_seen_o), 64'd1);
    tick(3);
    chk("check_seen_sticky", 64'(check_seen_o), 64'd1);
    clear_status_i = 1'b1; tick(1); clear_status_i = 1'b0;
    chk("check_seen_cleared", 64'(check_seen_o), 64'd0);
    state0_i = 1'b1; clear_status_i = 1'b1; tick(1);
    state0_i = 1'b0; clear_status_i = 1'b0;
    chk("check_seen_set_priority", 64'(check_seen_o), 64'd1);
    chk("count_zero_after_clear", 64'(issue_count_o), 64'd0);
    force dut.issue_count_o = 16'hFFFE;
    tick(1);
    release dut.issue_count_o;
    tick(1);
    chk("count_preset", 64'(issue_count_o), 64'hFFFE);
    push(8'h44, 32'h44, 64'h44, 16'd0, 8'd1, t);
    exp_strobe(8'h44, 32'h44, 64'h44, t + 2);
    exp_strobe(8'h44, 32'h44, 64'h44, t + 5);
    done_q.push_back(t + 8);
    wait_idle(40);
    chk("count_saturated", 64'(issue_count_o), 64'hFFFF);

    // Reset asserted while a strobe is on the port, with one more queued
    push(8'h11, 32'h22, 64'h33, 16'd2, 8'd0, t);
    exp_strobe(8'h11, 32'h22, 64'h33, t + 4);
    push(8'h12, 32'h12, 64'h12, 16'd0, 8'd0, t0);
    begin
      int k = 0;
      @(negedge clk_i);
      while (!cmd_valid_o && k < 20) begin
        @(negedge clk_i);
        k++;
      end
      chk("saw_strobe_before_reset", 64'(cmd_valid_o), 64'd1);
    end
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_cmd_valid",  64'(cmd_valid_o),   64'd0);
    chk("mid_rst_cmd_field",  64'(cmd_command_o), 64'd0);
    chk("mid_rst_busy",       64'(busy_o),        64'd0);
    chk("mid_rst_count",      64'(issue_count_o), 64'd0);
    chk("mid_rst_check_seen", 64'(check_seen_o),  64'd0);
    chk("mid_rst_ready",      64'(host_if.ready), 64'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    tick(20);
    chk("post_rst_busy",  64'(busy_o),        64'd0);
    chk("post_rst_count", 64'(issue_count_o), 64'd0);

    chk("strobe_queue_drained", 64'(exp_q.size()),  64'd0);
    chk("done_queue_drained",   64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
